// File: rtl/id_ex_stage_buffer.sv
// ---------------------------------------------------------------------------
// id_ex_stage_buffer
//
// Pipeline boundary between decode (ID) and execute (EX) of the RISC-V core.
// Holds the decoded control bundle, PC, PC+4, immediate, operand data and
// register indices. Valid/ready handshakes sit on both sides.
//
// With SKID_EN=1 a second (skid) entry absorbs the instruction that decode
// launches in the same cycle that EX stalls. in_ready_o then comes from a flop,
// so there is no combinational path from out_ready_i back into decode.
// With SKID_EN=0 the buffer is a single entry and its ready signal is
// combinational.
//
// Parameters
//   DATA_W   width of PC, PC+4, immediate and operand data
//   RADDR_W  width of register indices
//   CTRL_W   width of the packed control bundle
//   SKID_EN  1: two entries, registered ready; 0: one entry, combinational ready
//
// Ports
//   clk_i, reset_i        clock (rising edge), asynchronous active-high reset
//   flush_i               synchronous flush; drops every held entry
//   in_valid_i/in_ready_o handshake with decode
//   ctrl_i .. rd_idx_i    instruction payload from decode
//   out_valid_o/out_ready_i handshake with execute
//   ctrl_o .. rd_idx_o    head-entry payload; ctrl_o reads 0 while invalid
// ---------------------------------------------------------------------------
module id_ex_stage_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 16,
  parameter int unsigned SKID_EN = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,

  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [CTRL_W-1:0]  ctrl_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [DATA_W-1:0]  pc_p4_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [DATA_W-1:0]  rs1_data_i,
  input  logic [DATA_W-1:0]  rs2_data_i,
  input  logic [RADDR_W-1:0] rs1_idx_i,
  input  logic [RADDR_W-1:0] rs2_idx_i,
  input  logic [RADDR_W-1:0] rd_idx_i,

  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [DATA_W-1:0]  pc_o,
  output logic [DATA_W-1:0]  pc_p4_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [DATA_W-1:0]  rs1_data_o,
  output logic [DATA_W-1:0]  rs2_data_o,
  output logic [RADDR_W-1:0] rs1_idx_o,
  output logic [RADDR_W-1:0] rs2_idx_o,
  output logic [RADDR_W-1:0] rd_idx_o
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  pc_p4;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [RADDR_W-1:0] rs1_idx;
    logic [RADDR_W-1:0] rs2_idx;
    logic [RADDR_W-1:0] rd_idx;
  } entry_t;

  // Encoding is {skid_v, main_v}, so each valid bit is a state-register bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t state_q;
  state_t state_d;

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;

  logic main_v;
  logic skid_v;
  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_entry = '{
    ctrl:     ctrl_i,
    pc:       pc_i,
    pc_p4:    pc_p4_i,
    imm:      imm_i,
    rs1_data: rs1_data_i,
    rs2_data: rs2_data_i,
    rs1_idx:  rs1_idx_i,
    rs2_idx:  rs2_idx_i,
    rd_idx:   rd_idx_i
  };

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      // Ready is a flop bit; out_ready_i never reaches decode combinationally.
      assign in_ready_o = ~skid_v;
    end else begin : g_direct_ready
      // A full single entry can still accept when EX drains it this cycle.
      assign in_ready_o = ~main_v | out_ready_i;
    end
  endgenerate

  assign accept = in_valid_i & in_ready_o;
  assign pop    = main_v & out_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides any accept or pop in the same cycle, and payload loads are
  // suppressed so the held payload stays put.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept && (SKID_EN != 0)) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_valid_o = main_v;

  // Zero control on a bubble keeps every downstream write enable quiet.
  assign ctrl_o     = main_v ? main_q.ctrl : '0;
  assign pc_o       = main_q.pc;
  assign pc_p4_o    = main_q.pc_p4;
  assign imm_o      = main_q.imm;
  assign rs1_data_o = main_q.rs1_data;
  assign rs2_data_o = main_q.rs2_data;
  assign rs1_idx_o  = main_q.rs1_idx;
  assign rs2_idx_o  = main_q.rs2_idx;
  assign rd_idx_o   = main_q.rd_idx;

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_buffer
//
// Self-checking bench for id_ex_stage_buffer. It instantiates the skid build
// and the single-entry build side by side on shared stimulus.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_buffer;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
  } pay_t;

  typedef struct {
    logic        vin;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic        ordy;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [15:0] e_ctrl;
    logic [4:0]  e_rd;
    logic        e_rdy;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  logic in_valid;
  logic out_ready;
  pay_t in_pay;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_ctrl;
  logic [31:0] s_pc, s_pc_p4, s_imm, s_rs1_data, s_rs2_data;
  logic [4:0]  s_rs1_idx, s_rs2_idx, s_rd_idx;
  pay_t        s_out;

  logic        n_in_ready, n_out_valid;
  logic [15:0] n_ctrl;
  logic [31:0] n_pc, n_pc_p4, n_imm, n_rs1_data, n_rs2_data;
  logic [4:0]  n_rs1_idx, n_rs2_idx, n_rd_idx;
  pay_t        n_out;

  int tests = 0;
  int fails = 0;

  pay_t q_s[$];
  pay_t q_n[$];
  pay_t last_s;
  pay_t last_n;
  vec_t vecs[$];

  always #5 clock = ~clock;

  id_ex_stage_buffer #(.DATA_W(32), .RADDR_W(5), .CTRL_W(16), .SKID_EN(1)) dut (
    .clk_i(clock), .reset_i(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .ctrl_i(in_pay.ctrl), .pc_i(in_pay.pc), .pc_p4_i(in_pay.pc_p4), .imm_i(in_pay.imm),
    .rs1_data_i(in_pay.rs1_data), .rs2_data_i(in_pay.rs2_data),
    .rs1_idx_i(in_pay.rs1_idx), .rs2_idx_i(in_pay.rs2_idx), .rd_idx_i(in_pay.rd_idx),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .ctrl_o(s_ctrl), .pc_o(s_pc), .pc_p4_o(s_pc_p4), .imm_o(s_imm),
    .rs1_data_o(s_rs1_data), .rs2_data_o(s_rs2_data),
    .rs1_idx_o(s_rs1_idx), .rs2_idx_o(s_rs2_idx), .rd_idx_o(s_rd_idx)
  );

  id_ex_stage_buffer #(.DATA_W(32), .RADDR_W(5), .CTRL_W(16), .SKID_EN(0)) dut0 (
    .clk_i(clock), .reset_i(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .ctrl_i(in_pay.ctrl), .pc_i(in_pay.pc), .pc_p4_i(in_pay.pc_p4), .imm_i(in_pay.imm),
    .rs1_data_i(in_pay.rs1_data), .rs2_data_i(in_pay.rs2_data),
    .rs1_idx_i(in_pay.rs1_idx), .rs2_idx_i(in_pay.rs2_idx), .rd_idx_i(in_pay.rd_idx),
    .out_valid_o(n_out_valid), .out_ready_i(out_ready),
    .ctrl_o(n_ctrl), .pc_o(n_pc), .pc_p4_o(n_pc_p4), .imm_o(n_imm),
    .rs1_data_o(n_rs1_data), .rs2_data_o(n_rs2_data),
    .rs1_idx_o(n_rs1_idx), .rs2_idx_o(n_rs2_idx), .rd_idx_o(n_rd_idx)
  );

  assign s_out = {s_ctrl, s_pc, s_pc_p4, s_imm, s_rs1_data, s_rs2_data, s_rs1_idx, s_rs2_idx, s_rd_idx};
  assign n_out = {n_ctrl, n_pc, n_pc_p4, n_imm, n_rs1_data, n_rs2_data, n_rs1_idx, n_rs2_idx, n_rd_idx};

  function automatic pay_t mkPay(input logic [31:0] pc, input logic [15:0] ctrl, input logic [4:0] rd);
    pay_t p;
    p.ctrl     = ctrl;
    p.pc       = pc;
    p.pc_p4    = pc + 32'd4;
    p.imm      = ~pc;
    p.rs1_data = pc ^ 32'h5555_5555;
    p.rs2_data = pc + 32'h100;
    p.rs1_idx  = rd + 5'd1;
    p.rs2_idx  = rd + 5'd2;
    p.rd_idx   = rd;
    return p;
  endfunction

  function automatic pay_t randPay();
    pay_t p;
    p.ctrl     = 16'($urandom);
    p.pc       = $urandom;
    p.pc_p4    = $urandom;
    p.imm      = $urandom;
    p.rs1_data = $urandom;
    p.rs2_data = $urandom;
    p.rs1_idx  = 5'($urandom);
    p.rs2_idx  = 5'($urandom);
    p.rd_idx   = 5'($urandom);
    return p;
  endfunction

  // Head entry if one is held, otherwise the last head with control forced to zero.
  function automatic pay_t expView(input logic has_head, input pay_t head, input pay_t last);
    pay_t p;
    if (has_head) begin
      p = head;
    end else begin
      p = last;
      p.ctrl = '0;
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input pay_t p, input logic ordy, input logic fl);
    in_valid  = v;
    in_pay    = p;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic addVec(input logic vin, input logic [31:0] pc, input logic [15:0] ctrl, input logic [4:0] rd,
                        input logic ordy, input logic fl, input logic e_valid, input logic [31:0] e_pc,
                        input logic [15:0] e_ctrl, input logic [4:0] e_rd, input logic e_rdy);
    vec_t v;
    v.vin = vin; v.pc = pc; v.ctrl = ctrl; v.rd = rd; v.ordy = ordy; v.fl = fl;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_ctrl = e_ctrl; v.e_rd = e_rd; v.e_rdy = e_rdy;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    q_s.delete();
    q_n.delete();
    last_s = '0;
    last_n = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic exp_rdy_s, exp_rdy_n, acc_s, acc_n, pop_s, pop_n;
    pay_t head_s, head_n;

    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Streaming, stall/skid, flush and bubble gating on the skid build.
    addVec(1, 32'h00, 16'hA000, 5'd0,  1, 0,  0, 32'h00, 16'h0000, 5'd0,  1);
    addVec(1, 32'h04, 16'hA004, 5'd1,  1, 0,  1, 32'h00, 16'hA000, 5'd0,  1);
    addVec(1, 32'h08, 16'hA008, 5'd2,  1, 0,  1, 32'h04, 16'hA004, 5'd1,  1);
    addVec(1, 32'h0C, 16'hA00C, 5'd3,  1, 0,  1, 32'h08, 16'hA008, 5'd2,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  1, 32'h0C, 16'hA00C, 5'd3,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  0, 32'h0C, 16'h0000, 5'd3,  1);
    addVec(1, 32'h10, 16'hA010, 5'd4,  0, 0,  0, 32'h0C, 16'h0000, 5'd3,  1);
    addVec(1, 32'h14, 16'hA014, 5'd5,  0, 0,  1, 32'h10, 16'hA010, 5'd4,  1);
    addVec(1, 32'h18, 16'hA018, 5'd6,  0, 0,  1, 32'h10, 16'hA010, 5'd4,  0);
    addVec(1, 32'h18, 16'hA018, 5'd6,  1, 0,  1, 32'h10, 16'hA010, 5'd4,  0);
    addVec(1, 32'h18, 16'hA018, 5'd6,  1, 0,  1, 32'h14, 16'hA014, 5'd5,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  1, 32'h18, 16'hA018, 5'd6,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  0, 32'h18, 16'h0000, 5'd6,  1);
    addVec(1, 32'h20, 16'hA020, 5'd8,  0, 0,  0, 32'h18, 16'h0000, 5'd6,  1);
    addVec(1, 32'h24, 16'hA024, 5'd9,  0, 0,  1, 32'h20, 16'hA020, 5'd8,  1);
    addVec(1, 32'h28, 16'hA028, 5'd10, 0, 1,  1, 32'h20, 16'hA020, 5'd8,  0);
    addVec(0, 32'h00, 16'h0000, 5'd0,  0, 0,  0, 32'h20, 16'h0000, 5'd8,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  0, 0,  0, 32'h20, 16'h0000, 5'd8,  1);
    addVec(1, 32'h30, 16'hFFFF, 5'd7,  1, 0,  0, 32'h20, 16'h0000, 5'd8,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  1, 32'h30, 16'hFFFF, 5'd7,  1);
    addVec(0, 32'h00, 16'h0000, 5'd0,  1, 0,  0, 32'h30, 16'h0000, 5'd7,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vin, mkPay(vecs[i].pc, vecs[i].ctrl, vecs[i].rd), vecs[i].ordy, vecs[i].fl);
      @(negedge clock);
      checkOutput($sformatf("vec%0d out_valid", i), 256'(s_out_valid), 256'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d pc_o", i), 256'(s_pc), 256'(vecs[i].e_pc));
      checkOutput($sformatf("vec%0d ctrl_o", i), 256'(s_ctrl), 256'(vecs[i].e_ctrl));
      checkOutput($sformatf("vec%0d rd_idx_o", i), 256'(s_rd_idx), 256'(vecs[i].e_rd));
      checkOutput($sformatf("vec%0d in_ready", i), 256'(s_in_ready), 256'(vecs[i].e_rdy));
      @(posedge clock);
      #1;
    end

    // Asynchronous reset while the skid build holds two entries.
    applyStimulus(1'b1, mkPay(32'h50, 16'h1234, 5'd11), 1'b0, 1'b0);
    @(posedge clock);
    #1;
    applyStimulus(1'b1, mkPay(32'h54, 16'h5678, 5'd12), 1'b0, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("pre-reset in_ready", 256'(s_in_ready), 256'(1'b0));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset out_valid", 256'(s_out_valid), 256'(1'b0));
    checkOutput("async reset ctrl_o", 256'(s_ctrl), 256'(16'h0));
    checkOutput("async reset pc_o", 256'(s_pc), 256'(32'h0));
    checkOutput("async reset in_ready", 256'(s_in_ready), 256'(1'b1));
    checkOutput("async reset single out_valid", 256'(n_out_valid), 256'(1'b0));
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(posedge clock);
    #1;

    // Single-entry build: ready follows out_ready_i within the cycle.
    applyStimulus(1'b1, mkPay(32'h40, 16'hC040, 5'd13), 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("single empty in_ready", 256'(n_in_ready), 256'(1'b1));
    @(posedge clock);
    #1;
    applyStimulus(1'b1, mkPay(32'h44, 16'hC044, 5'd14), 1'b0, 1'b0);
    #2;
    checkOutput("single full stalled in_ready", 256'(n_in_ready), 256'(1'b0));
    out_ready = 1'b1;
    #2;
    checkOutput("single full draining in_ready", 256'(n_in_ready), 256'(1'b1));
    @(posedge clock);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("single accept+pop out_valid", 256'(n_out_valid), 256'(1'b1));
    checkOutput("single accept+pop pc_o", 256'(n_pc), 256'(32'h44));

    // Random traffic against a FIFO model for both builds.
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      applyStimulus(($urandom_range(0, 99) < 70), randPay(), ($urandom_range(0, 99) < 55),
                    ($urandom_range(0, 99) < 5));
      @(negedge clock);
      head_s = (q_s.size() > 0) ? q_s[0] : last_s;
      head_n = (q_n.size() > 0) ? q_n[0] : last_n;
      exp_rdy_s = (q_s.size() < 2);
      exp_rdy_n = (q_n.size() == 0) || out_ready;
      checkOutput("rand skid in_ready", 256'(s_in_ready), 256'(exp_rdy_s));
      checkOutput("rand skid out_valid", 256'(s_out_valid), 256'(q_s.size() > 0));
      checkOutput("rand skid payload", 256'(s_out), 256'(expView(q_s.size() > 0, head_s, last_s)));
      checkOutput("rand single in_ready", 256'(n_in_ready), 256'(exp_rdy_n));
      checkOutput("rand single out_valid", 256'(n_out_valid), 256'(q_n.size() > 0));
      checkOutput("rand single payload", 256'(n_out), 256'(expView(q_n.size() > 0, head_n, last_n)));
      acc_s = in_valid && exp_rdy_s;
      acc_n = in_valid && exp_rdy_n;
      pop_s = (q_s.size() > 0) && out_ready;
      pop_n = (q_n.size() > 0) && out_ready;
      @(posedge clock);
      if (flush) begin
        q_s.delete();
        q_n.delete();
      end else begin
        if (pop_s) void'(q_s.pop_front());
        if (acc_s) q_s.push_back(in_pay);
        if (pop_n) void'(q_n.pop_front());
        if (acc_n) q_n.push_back(in_pay);
      end
      if (q_s.size() > 0) last_s = q_s[0];
      if (q_n.size() > 0) last_n = q_n[0];
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
